lcd_cmd_host: RTL and testbench
===============================

LCD_CMD_HOST -- requirements
Module: lcd_cmd_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, max cycles spent waiting in WAIT_RDY or WAIT_DONE.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle run request, sampled only in IDLE.
REQ-005 SHALL have port CROM_EN  output  1  command-ROM read enable, active-low.
REQ-006 SHALL have port CROM_A  output  5  command-ROM address, 32 entries.
REQ-007 SHALL have port CROM_Q  input  3  command word, valid one cycle after CROM_EN=0 with CROM_A.
REQ-008 SHALL have port cmd  output  3  command to LCD controller (0 write, 1 up, 2 down, 3 left, 4 right, 5 avg, 6 mirror-x, 7 mirror-y).
REQ-009 SHALL have port cmd_valid  output  1  one-cycle command strobe.
REQ-010 SHALL have port busy  input  1  controller busy; commands are issued only while it is low.
REQ-011 SHALL have port done  input  1  controller finished the image write.
REQ-012 SHALL have ports IRB_RW (input 1, write when 0) and IRB_D (input 8), monitored only.
REQ-013 SHALL have ports host_done (output 1), err (output 1) and cmd_cnt (output 6, commands issued).

Function
REQ-014 SHALL implement the states IDLE, WAIT_RDY, FETCH, ISSUE, GAP, WAIT_DONE, FIN and ERR.
REQ-015 SHALL handle IDLE as follows: start=1 clears cmd_cnt, CROM_A, host_done and err, and moves to WAIT_RDY; start in any other state is ignored.
REQ-016 SHALL handle WAIT_RDY as follows: when busy=0 is sampled, drive CROM_EN=0 for one cycle and go to FETCH; if busy stays high for TIMEOUT cycles, go to ERR.
REQ-017 SHALL handle FETCH as a single wait cycle for the ROM, then go to ISSUE.
REQ-018 SHALL handle ISSUE as follows: cmd=CROM_Q and cmd_valid=1 for exactly one cycle, cmd_cnt increments; cmd=0 goes to WAIT_DONE, otherwise CROM_A increments and the state goes to GAP.
REQ-019 SHALL handle GAP as follows: cmd_valid=0 for one cycle, so the controller can raise busy, then go to WAIT_RDY.
REQ-020 SHALL force the next issue to cmd=0 without a ROM fetch when a non-write command is issued at CROM_A=31, so CROM_A never wraps.
REQ-021 SHALL handle WAIT_DONE as follows: done=1 goes to FIN; TIMEOUT cycles without done go to ERR.
REQ-022 SHALL handle FIN as follows: host_done=1 is held and the state returns to IDLE; host_done stays high until the next accepted start.
REQ-023 SHALL handle ERR as follows: err=1 and host_done=1 are held, and the state returns to IDLE.
REQ-024 SHALL restart the timeout counter on every entry to WAIT_RDY or WAIT_DONE.
REQ-025 SHALL drive cmd_valid=0 in every state except ISSUE.
REQ-026 SHALL hold cmd at its last issued value.
REQ-027 SHALL saturate cmd_cnt at 63.

Reset
REQ-028 SHALL, on reset low, enter IDLE immediately, including in the middle of a run.
REQ-029 SHALL drive these reset values: CROM_EN=1, CROM_A=0, cmd=0, cmd_valid=0, cmd_cnt=0, host_done=0, err=0, timeout counter=0.
REQ-030 SHALL not issue any command in the first cycle after reset releases.

Configuration
REQ-031 SHALL, with LCD_HOST_CKSUM_EN defined, add output cksum (16 bits) holding the modulo-2^16 sum of IRB_D over all cycles with IRB_RW=0, cleared on an accepted start.
REQ-032 SHALL, with LCD_HOST_CKSUM_EN defined, add output wr_cnt (7 bits) counting those same cycles.
REQ-033 SHALL, without LCD_HOST_CKSUM_EN, have neither the ports nor the logic of REQ-031/REQ-032.

Structure
REQ-034 SHALL place the command encodings, the state enumeration and the TIMEOUT default in shared package lcd_pkg.
REQ-035 SHALL implement the timeout counter as sub-module lcd_host_timer (load, count, expire at TIMEOUT).

Verification
REQ-036 SHALL cover: ROM holds {4,2,5,0} with busy=0 after 2 cycles -> cmd sequence 4,2,5,0, each strobe one cycle with a gap between strobes; done after 70 cycles -> host_done=1, cmd_cnt=4, err=0.
REQ-037 SHALL cover: all 32 ROM entries hold 1 -> 32 commands of value 1 followed by a forced cmd=0; cmd_cnt=33; CROM_A stops at 31.
REQ-038 SHALL cover: busy held high after start with TIMEOUT=15 -> ERR after 15 cycles, err=1, no cmd_valid pulse.
REQ-039 SHALL cover: reset low asserted during WAIT_DONE -> all outputs at reset values in the same cycle; a new start runs normally.
REQ-040 SHALL cover, with LCD_HOST_CKSUM_EN defined: 64 IRB writes of value 0xFF -> cksum=0x3FC0, wr_cnt=64.
REQ-041 SHALL cover: start pulses during ISSUE or WAIT_RDY -> ignored, with cmd_cnt and CROM_A unchanged by them.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command host: command encodings,
// host FSM states and the default wait timeout.
package lcd_pkg;

  // Default number of cycles the host waits for busy to drop or done to rise
  localparam int unsigned TimeoutDefault = 1023;

  // Commands understood by the LCD controller
  typedef enum logic [2:0] {
    CmdWrite   = 3'd0,
    CmdUp      = 3'd1,
    CmdDown    = 3'd2,
    CmdLeft    = 3'd3,
    CmdRight   = 3'd4,
    CmdAvg     = 3'd5,
    CmdMirrorX = 3'd6,
    CmdMirrorY = 3'd7
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StFetch,
    StIssue,
    StGap,
    StWaitDone,
    StFin,
    StErr
  } lcd_state_e;

  localparam logic [4:0] CromLastAddr = 5'd31;
  localparam logic [5:0] CmdCntMax    = 6'd63;

endpackage

// File: rtl/lcd_host_timer.sv
// Wait timer for the LCD command host. load restarts the count at zero,
// count advances it, expired flags the TIMEOUT-th waiting cycle.
module lcd_host_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned Width = $clog2(TIMEOUT + 1);

  logic [Width-1:0] cnt_q;

  // Cycle counter; the host stops counting once expired, so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign expired = (cnt_q == Width'(TIMEOUT - 1));

endmodule

// File: rtl/lcd_cmd_host.sv
// LCD command host: reads a command list from a 32-entry ROM and feeds it to
// the LCD controller one strobe at a time, waiting for busy to drop between
// commands and for done after the final write command.
// Optional feature: define LCD_HOST_CKSUM_EN to add the cksum/wr_cnt outputs
// that sum and count IRB writes.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       CROM_EN,
  output logic [4:0] CROM_A,
  input  logic [2:0] CROM_Q,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  input  logic       IRB_RW,
  input  logic [7:0] IRB_D,
  output logic       host_done,
  output logic       err,
  output logic [5:0] cmd_cnt
`ifdef LCD_HOST_CKSUM_EN
  ,
  output logic [15:0] cksum,
  output logic [6:0]  wr_cnt
`endif
);

  lcd_state_e state_q, state_d;
  lcd_cmd_e   cmd_q, cmd_d;
  logic [4:0] crom_a_q, crom_a_d;
  logic [5:0] cmd_cnt_q, cmd_cnt_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       host_done_q, host_done_d;
  logic       err_q, err_d;
  // Set after a non-write command at the last ROM address: next issue is a write
  logic       force_zero_q, force_zero_d;
  logic       crom_en;
  logic       tmr_load, tmr_count, tmr_expired;

  lcd_host_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  // Next-state and output decode; ROM read is requested in the cycle busy is seen low
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    crom_a_d     = crom_a_q;
    cmd_cnt_d    = cmd_cnt_q;
    cmd_valid_d  = 1'b0;
    host_done_d  = host_done_q;
    err_d        = err_q;
    force_zero_d = force_zero_q;
    crom_en      = 1'b1;
    tmr_load     = 1'b0;
    tmr_count    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cmd_cnt_d    = '0;
          crom_a_d     = '0;
          host_done_d  = 1'b0;
          err_d        = 1'b0;
          force_zero_d = 1'b0;
          tmr_load     = 1'b1;
          state_d      = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (!busy) begin
          crom_en = force_zero_q;
          state_d = StFetch;
        end else if (tmr_expired) begin
          err_d       = 1'b1;
          host_done_d = 1'b1;
          state_d     = StErr;
        end else begin
          tmr_count = 1'b1;
        end
      end
      StFetch: begin
        // ROM data is valid now; register it so the strobe lines up with ISSUE
        cmd_d       = force_zero_q ? CmdWrite : lcd_cmd_e'(CROM_Q);
        cmd_valid_d = 1'b1;
        cmd_cnt_d   = (cmd_cnt_q == CmdCntMax) ? cmd_cnt_q : cmd_cnt_q + 6'd1;
        state_d     = StIssue;
      end
      StIssue: begin
        if (cmd_q == CmdWrite) begin
          tmr_load = 1'b1;
          state_d  = StWaitDone;
        end else begin
          if (crom_a_q == CromLastAddr) begin
            force_zero_d = 1'b1;
          end else begin
            crom_a_d = crom_a_q + 5'd1;
          end
          state_d = StGap;
        end
      end
      StGap: begin
        tmr_load = 1'b1;
        state_d  = StWaitRdy;
      end
      StWaitDone: begin
        if (done) begin
          host_done_d = 1'b1;
          state_d     = StFin;
        end else if (tmr_expired) begin
          err_d       = 1'b1;
          host_done_d = 1'b1;
          state_d     = StErr;
        end else begin
          tmr_count = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cmd_q        <= CmdWrite;
      crom_a_q     <= '0;
      cmd_cnt_q    <= '0;
      cmd_valid_q  <= 1'b0;
      host_done_q  <= 1'b0;
      err_q        <= 1'b0;
      force_zero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      crom_a_q     <= crom_a_d;
      cmd_cnt_q    <= cmd_cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      host_done_q  <= host_done_d;
      err_q        <= err_d;
      force_zero_q <= force_zero_d;
    end
  end

  assign CROM_EN   = crom_en;
  assign CROM_A    = crom_a_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign host_done = host_done_q;
  assign err       = err_q;
  assign cmd_cnt   = cmd_cnt_q;

`ifdef LCD_HOST_CKSUM_EN
  logic [15:0] cksum_q;
  logic [6:0]  wr_cnt_q;
  logic        start_accepted;

  assign start_accepted = (state_q == StIdle) && start;

  // Running sum and count of IRB write cycles since the last accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_q  <= '0;
      wr_cnt_q <= '0;
    end else if (start_accepted) begin
      cksum_q  <= '0;
      wr_cnt_q <= '0;
    end else if (!IRB_RW) begin
      cksum_q  <= cksum_q + {8'h00, IRB_D};
      wr_cnt_q <= wr_cnt_q + 7'd1;
    end
  end

  assign cksum  = cksum_q;
  assign wr_cnt = wr_cnt_q;
`else
  logic unused_irb;
  assign unused_irb = ^{IRB_RW, IRB_D};
`endif

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host. u_dut uses the default timeout with a ROM
// and busy model; u_dut_to uses TIMEOUT=15 with busy stuck high.
module tb_lcd_cmd_host;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done = 1'b0;
  logic       IRB_RW = 1'b1;
  logic [7:0] IRB_D = 8'h00;

  logic       CROM_EN, cmd_valid, host_done, err;
  logic [4:0] CROM_A;
  logic [2:0] CROM_Q, cmd;
  logic [5:0] cmd_cnt;

  logic       CROM_EN2, cmd_valid2, host_done2, err2;
  logic [4:0] CROM_A2;
  logic [2:0] cmd2;
  logic [5:0] cmd_cnt2;

`ifdef LCD_HOST_CKSUM_EN
  logic [15:0] cksum, cksum2;
  logic [6:0]  wr_cnt, wr_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_cmd_host u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .CROM_EN  (CROM_EN),
    .CROM_A   (CROM_A),
    .CROM_Q   (CROM_Q),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .busy     (busy),
    .done     (done),
    .IRB_RW   (IRB_RW),
    .IRB_D    (IRB_D),
    .host_done(host_done),
    .err      (err),
    .cmd_cnt  (cmd_cnt)
`ifdef LCD_HOST_CKSUM_EN
    ,
    .cksum    (cksum),
    .wr_cnt   (wr_cnt)
`endif
  );

  lcd_cmd_host #(
    .TIMEOUT(15)
  ) u_dut_to (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .CROM_EN  (CROM_EN2),
    .CROM_A   (CROM_A2),
    .CROM_Q   (3'd0),
    .cmd      (cmd2),
    .cmd_valid(cmd_valid2),
    .busy     (1'b1),
    .done     (1'b0),
    .IRB_RW   (IRB_RW),
    .IRB_D    (IRB_D),
    .host_done(host_done2),
    .err      (err2),
    .cmd_cnt  (cmd_cnt2)
`ifdef LCD_HOST_CKSUM_EN
    ,
    .cksum    (cksum2),
    .wr_cnt   (wr_cnt2)
`endif
  );

  // Synchronous command ROM: data appears one edge after a read with CROM_EN low
  logic [2:0] rom [32];
  logic [2:0] rom_q = 3'd0;
  always @(posedge clk) if (!CROM_EN) rom_q <= rom[CROM_A];
  assign CROM_Q = rom_q;

  // Controller model: busy goes high for busy_len cycles after each strobe
  int busy_len = 2;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (cmd_valid) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign busy = (busy_cnt != 0);

  // Strobe monitor
  logic [2:0] strobes[$];
  int dbl_cnt = 0;
  int fetch_cnt = 0;
  int strobe2_cnt = 0;
  logic prev_valid = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmd_valid) begin
      strobes.push_back(cmd);
      if (prev_valid) dbl_cnt++;
    end
    prev_valid = cmd_valid;
    if (!CROM_EN) fetch_cnt++;
    if (cmd_valid2) strobe2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    strobes.delete();
    dbl_cnt = 0;
    fetch_cnt = 0;
    strobe2_cnt = 0;
  endtask

  task automatic load_rom(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input logic [2:0] d);
    for (int i = 0; i < 32; i++) rom[i] = 3'd0;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
    rom[3] = d;
  endtask

  // Start is high for exactly one rising edge; returns 1 time unit after it
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_host_done(input string tag, input int budget);
    int n = 0;
    while (!host_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, host_done, 1);
  endtask

  function automatic logic [31:0] strobe_at(input int i);
    if (i < strobes.size()) return 32'(strobes[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones;
    int n;
    load_rom(3'd4, 3'd2, 3'd5, 3'd0);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_crom_en", CROM_EN, 1);
    check("rst_crom_a", CROM_A, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_cnt", cmd_cnt, 0);
    check("rst_host_done", host_done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;

    // Basic sequence 4,2,5,0 with done 70 cycles after start
    busy_len = 2;
    clear_mon();
    pulse_start();
    repeat (69) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    wait_host_done("t1_host_done", 50);
    check("t1_err", err, 0);
    check("t1_cmd_cnt", cmd_cnt, 4);
    check("t1_n_strobes", strobes.size(), 4);
    check("t1_cmd0", strobe_at(0), 4);
    check("t1_cmd1", strobe_at(1), 2);
    check("t1_cmd2", strobe_at(2), 5);
    check("t1_cmd3", strobe_at(3), 0);
    check("t1_no_back_to_back", dbl_cnt, 0);

    // Full ROM of "up" commands: forced write after address 31
    for (int i = 0; i < 32; i++) rom[i] = 3'd1;
    busy_len = 1;
    done = 1'b1;
    clear_mon();
    pulse_start();
    wait_host_done("t2_host_done", 400);
    ones = 0;
    foreach (strobes[i]) if (strobes[i] == 3'd1) ones++;
    check("t2_cmd_cnt", cmd_cnt, 33);
    check("t2_n_strobes", strobes.size(), 33);
    check("t2_ones", ones, 32);
    check("t2_last_cmd", strobe_at(32), 0);
    check("t2_rom_reads", fetch_cnt, 32);
    check("t2_crom_a", CROM_A, 31);
    check("t2_err", err, 0);
    check("t2_no_back_to_back", dbl_cnt, 0);
    done = 1'b0;

    // Timeout instance: busy stuck high, ERR after 15 waiting cycles
    load_rom(3'd3, 3'd6, 3'd0, 3'd0);
    busy_len = 2;
    clear_mon();
    pulse_start();
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("t3_err_early", err2, 0);
    check("t3_host_done_early", host_done2, 0);
    @(posedge clk);
    @(negedge clk);
    check("t3_err", err2, 1);
    check("t3_host_done", host_done2, 1);
    check("t3_no_strobe", strobe2_cnt, 0);
    check("t3_cmd_cnt", cmd_cnt2, 0);

    // Reset while the main instance waits for done
    n = 0;
    while (strobes.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_wait_done", strobes.size(), 3);
    repeat (3) @(negedge clk);
    check("t4_pre_cmd_cnt", cmd_cnt, 3);
    check("t4_pre_crom_a", CROM_A, 2);
    #2 reset = 1'b0;
    #1;
    check("t4_crom_en", CROM_EN, 1);
    check("t4_crom_a", CROM_A, 0);
    check("t4_cmd", cmd, 0);
    check("t4_cmd_valid", cmd_valid, 0);
    check("t4_cmd_cnt", cmd_cnt, 0);
    check("t4_host_done", host_done, 0);
    check("t4_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_first_cycle_no_strobe", cmd_valid, 0);
    load_rom(3'd4, 3'd2, 3'd5, 3'd0);
    done = 1'b1;
    clear_mon();
    pulse_start();
    wait_host_done("t4_rerun_host_done", 200);
    check("t4_rerun_cmd_cnt", cmd_cnt, 4);
    check("t4_rerun_err", err, 0);
    check("t4_rerun_last", strobe_at(3), 0);

    // Start pulses during ISSUE and WAIT_RDY are ignored
    busy_len = 4;
    clear_mon();
    pulse_start();
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_strobe", cmd_valid, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5_issue_crom_a", CROM_A, 1);
    check("t5_issue_cmd_cnt", cmd_cnt, 1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5_wait_crom_a", CROM_A, 1);
    check("t5_wait_cmd_cnt", cmd_cnt, 1);
    wait_host_done("t5_host_done", 200);
    check("t5_cmd_cnt", cmd_cnt, 4);
    check("t5_n_strobes", strobes.size(), 4);
    check("t5_last", strobe_at(3), 0);
    done = 1'b0;

`ifdef LCD_HOST_CKSUM_EN
    // 64 IRB writes of 0xFF
    repeat (3) @(negedge clk);
    pulse_start();
    IRB_D  = 8'hFF;
    IRB_RW = 1'b0;
    repeat (64) @(posedge clk);
    #1 IRB_RW = 1'b1;
    @(negedge clk);
    check("t6_cksum", cksum, 32'h3FC0);
    check("t6_wr_cnt", wr_cnt, 64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
